// File: rtl/accum_bank_ctl_pkg.sv
// accum_pkg: shared FSM state type and the lane saturate/wrap adder.
package accum_pkg;

    localparam int MAX_W = 40;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} accum_state_e;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } sat_res_t;

    // Operands are zero-extended to MAX_W; w selects the real accumulator width.
    function automatic sat_res_t sat_add(input logic [MAX_W-1:0] acc, input logic [MAX_W-1:0] inc,
                                         input logic [5:0] w, input logic sat);
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] mask;
        sat_res_t         r;
        sum   = {1'b0, acc} + {1'b0, inc};
        mask  = (MAX_W'(1) << w) - MAX_W'(1);
        r.ovf = sum[w];
        r.val = sum[w] ? (sat ? mask : sum[MAX_W-1:0] & mask) : sum[MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/accum_bank_ctl_if.sv
// accum_bank_ctl_if: job control, sample input and result handshake of the accumulator bank.
interface accum_bank_ctl_if #(
    parameter int NUM_CH = 32,
    parameter int IN_W   = 17,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  accum_i [NUM_CH];
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic             busy;

    modport master (output start, len, in_valid, accum_i, out_ready,
                    input  in_ready, out_valid, result, ovf, busy);
    modport slave  (input  start, len, in_valid, accum_i, out_ready,
                    output in_ready, out_valid, result, ovf, busy);
endinterface

// File: rtl/accum_bank_ctl_lane.sv
// accum_lane: one channel accumulator with saturate/wrap and a sticky overflow flag.
module accum_lane
    import accum_pkg::*;
#(
    parameter int IN_W     = 17,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  in_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    sat_res_t         r;
    logic             unused_hi;

    always_comb begin
        r     = sat_add(MAX_W'(acc_q), MAX_W'(in_i), 6'(ACC_W), SATURATE);
        acc_d = clr_i ? '0 : en_i ? r.val[ACC_W-1:0] : acc_q;
        ovf_d = clr_i ? 1'b0 : ovf_q | (en_i & r.ovf);
    end

    assign unused_hi = ^r.val[MAX_W-1:ACC_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/accum_bank_ctl.sv
// accum_bank_ctl: NUM_CH-lane accumulator bank; runs LEN-beat jobs and holds
// per-channel sums until the downstream handshake.
module accum_bank_ctl
    import accum_pkg::*;
#(
    parameter int NUM_CH   = 32,
    parameter int IN_W     = 17,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    accum_bank_ctl_if.slave bus_io
);
    accum_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             go, beat, last;
    logic [ACC_W-1:0] res [NUM_CH];
    logic [NUM_CH-1:0] ovf;

    // A new job is taken from IDLE, or straight out of HOLD as the result is consumed.
    always_comb begin
        go      = bus_io.start & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus_io.out_ready));
        beat    = bus_io.in_valid & (state_q == ST_ACCUM);
        last    = beat & (cnt_q == len_q - CNT_W'(1));
        cnt_d   = go ? '0 : beat ? cnt_q + CNT_W'(1) : cnt_q;
        len_d   = go ? bus_io.len : len_q;
        state_d = state_q;
        if (go)
            state_d = (|bus_io.len) ? ST_ACCUM : ST_HOLD;
        else if (last)
            state_d = ST_HOLD;
        else if ((state_q == ST_HOLD) & bus_io.out_ready)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .clr_i  (go),
            .en_i   (beat),
            .in_i   (bus_io.accum_i[i]),
            .acc_o  (res[i]),
            .ovf_o  (ovf[i])
        );
    end

    assign bus_io.result    = res;
    assign bus_io.ovf       = ovf;
    assign bus_io.in_ready  = state_q == ST_ACCUM;
    assign bus_io.out_valid = state_q == ST_HOLD;
    assign bus_io.busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_accum_bank_ctl.sv
// tb_accum_bank_ctl: three banks (24-bit saturating, 18-bit saturating, 18-bit wrapping)
// share one stimulus stream and are checked every cycle against a job-level model.
module tb_accum_bank_ctl;
    localparam int NCH = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        st = 1'b0;
    logic [7:0]  ln = '0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [16:0] acc [NCH];

    int  total = 0;
    int  bad = 0;
    bit  armed = 1'b0;

    int     rem = 0;
    bit     hold = 1'b0;
    longint ex [3][NCH];
    bit     eo [3][NCH];
    int     aw [3] = '{24, 18, 18};
    bit     sat [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    accum_bank_ctl_if #(.ACC_W(24)) ia ();
    accum_bank_ctl_if #(.ACC_W(18)) ib ();
    accum_bank_ctl_if #(.ACC_W(18)) ic ();

    assign ia.start = st;   assign ib.start = st;   assign ic.start = st;
    assign ia.len = ln;     assign ib.len = ln;     assign ic.len = ln;
    assign ia.in_valid = iv; assign ib.in_valid = iv; assign ic.in_valid = iv;
    assign ia.out_ready = ordy; assign ib.out_ready = ordy; assign ic.out_ready = ordy;
    assign ia.accum_i = acc; assign ib.accum_i = acc; assign ic.accum_i = acc;

    accum_bank_ctl #(.ACC_W(24), .SATURATE(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus_io(ia));
    accum_bank_ctl #(.ACC_W(18), .SATURATE(1'b1)) dut_b (.clk(clk), .reset_n(reset_n), .bus_io(ib));
    accum_bank_ctl #(.ACC_W(18), .SATURATE(1'b0)) dut_c (.clk(clk), .reset_n(reset_n), .bus_io(ic));

    function automatic longint res(int n, int k);
        return n == 0 ? longint'(ia.result[k]) : n == 1 ? longint'(ib.result[k]) : longint'(ic.result[k]);
    endfunction

    function automatic bit ovb(int n, int k);
        return n == 0 ? ia.ovf[k] : n == 1 ? ib.ovf[k] : ic.ovf[k];
    endfunction

    function automatic logic [2:0] ctl(int n);
        return n == 0 ? {ia.in_ready, ia.out_valid, ia.busy} :
               n == 1 ? {ib.in_ready, ib.out_valid, ib.busy} : {ic.in_ready, ic.out_valid, ic.busy};
    endfunction

    task automatic model_reset();
        rem = 0;
        hold = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < NCH; k++) begin
                ex[n][k] = 0;
                eo[n][k] = 1'b0;
            end
    endtask

    // One clock of the job-level model: jobs are "beats remaining" plus a pending-result flag.
    task automatic model_step();
        bit     idle;
        longint s, lim;
        idle = (rem == 0) && !hold;
        if (st && (idle || (hold && ordy))) begin
            model_reset();
            rem = int'(ln);
            hold = (ln == 0);
        end else if (rem > 0 && iv) begin
            for (int n = 0; n < 3; n++)
                for (int k = 0; k < NCH; k++) begin
                    s = ex[n][k] + longint'(acc[k]);
                    lim = longint'(1) << aw[n];
                    if (s >= lim) begin
                        eo[n][k] = 1'b1;
                        ex[n][k] = sat[n] ? lim - 1 : s - lim;
                    end else
                        ex[n][k] = s;
                end
            rem--;
            hold = (rem == 0);
        end else if (hold && ordy)
            hold = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #2;
    endtask

    task automatic setacc(int v);
        for (int k = 0; k < NCH; k++) acc[k] = 17'(v);
    endtask

    task automatic chk(string name, longint got, longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int n = 0; n < 3; n++) begin
                bit ok;
                logic [2:0] want;
                ok = 1'b1;
                total++;
                want = {rem > 0, hold, (rem > 0) || hold};
                if (ctl(n) !== want) begin
                    ok = 1'b0;
                    $display("FAIL ctl inst%0d got %b want %b at %0t", n, ctl(n), want, $time);
                end
                for (int k = 0; k < NCH; k++)
                    if (ok && (res(n, k) !== ex[n][k] || ovb(n, k) !== eo[n][k])) begin
                        ok = 1'b0;
                        $display("FAIL lane inst%0d ch%0d got %0h/%0b want %0h/%0b at %0t",
                                 n, k, res(n, k), ovb(n, k), ex[n][k], eo[n][k], $time);
                    end
                if (!ok) bad++;
            end
        end
    end

    initial begin
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        setacc(0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        armed = 1'b1;
        tick();
        chk("reset in_ready", ia.in_ready, 0);
        chk("reset out_valid", ia.out_valid, 0);
        chk("reset busy", ia.busy, 0);
        chk("reset result", ia.result[5], 0);

        // reset mid-job after three beats
        st = 1; ln = 8; tick();
        st = 0; iv = 1; setacc(5);
        tick(); tick(); tick();
        chk("partial sum", ia.result[2], 15);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async reset result", ia.result[2], 0);
        chk("async reset busy", ia.busy, 0);
        iv = 0; tick();
        chk("reset in_ready", ia.in_ready, 0);
        reset_n = 1'b1;
        tick();

        // gapped valid, channel k adds k+1
        st = 1; ln = 4;
        for (int k = 0; k < NCH; k++) acc[k] = 17'(k + 1);
        tick();
        st = 0;
        for (int i = 0; i < 6; i++) begin
            iv = pat[i];
            tick();
            if (i == 4) chk("no early out_valid", ia.out_valid, 0);
        end
        iv = 0;
        chk("gap out_valid", ia.out_valid, 1);
        chk("gap in_ready hold", ia.in_ready, 0);
        chk("gap ch0", ia.result[0], 4);
        chk("gap ch15", ia.result[15], 64);
        chk("gap ch31", ia.result[31], 128);
        ordy = 1; tick();
        chk("drain busy", ia.busy, 0);
        ordy = 0;

        // saturate vs wrap at 18 bits
        st = 1; ln = 3; tick();
        st = 0; iv = 1; setacc(17'h1FFFF);
        tick(); tick(); tick();
        iv = 0;
        chk("sat result", ib.result[0], 18'h3FFFF);
        chk("sat ovf", ib.ovf[0], 1);
        chk("wrap result", ic.result[7], 18'h1FFFD);
        chk("wrap ovf", ic.ovf[7], 1);
        chk("wide result", ia.result[0], 24'h5FFFD);
        chk("wide ovf", ia.ovf[0], 0);
        ordy = 1; tick(); ordy = 0;

        // zero-length job
        st = 1; ln = 0; iv = 1; setacc(9); tick();
        st = 0;
        chk("len0 out_valid", ia.out_valid, 1);
        chk("len0 in_ready", ia.in_ready, 0);
        chk("len0 result", ia.result[3], 0);
        tick();
        chk("len0 no beat", ia.result[3], 0);
        iv = 0; ordy = 1; tick(); ordy = 0;

        // stalled HOLD then back-to-back job
        st = 1; ln = 1; setacc(7); iv = 1; tick();
        st = 0; tick();
        iv = 0;
        chk("hold result", ia.result[0], 7);
        for (int i = 0; i < 10; i++) begin
            st = i[0]; ln = 5; tick();
        end
        chk("stall result", ia.result[0], 7);
        chk("stall out_valid", ia.out_valid, 1);
        ordy = 1; st = 1; ln = 2; tick();
        st = 0;
        chk("b2b in_ready", ia.in_ready, 1);
        chk("b2b out_valid", ia.out_valid, 0);
        chk("b2b cleared", ia.result[0], 0);
        ordy = 0; setacc(3); iv = 1; tick(); tick();
        iv = 0;
        chk("b2b result", ia.result[0], 6);
        chk("b2b done", ia.out_valid, 1);
        ordy = 1; tick(); ordy = 0;

        // start during ACCUM is ignored
        st = 1; ln = 3; setacc(2); tick();
        st = 0; iv = 1; st = 1; ln = 9; tick();
        st = 0; tick();
        chk("midjob in_ready", ia.in_ready, 1);
        chk("midjob sum", ia.result[0], 4);
        tick();
        iv = 0;
        chk("orig len done", ia.out_valid, 1);
        chk("orig len sum", ia.result[0], 6);
        ordy = 1; tick();
        chk("final idle", ia.busy, 0);
        ordy = 0;
        tick();
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
